classify_sequencer: RTL and testbench

CLASSIFY_SEQUENCER -- requirements
Module: classify_sequencer

---
 rtl/ocr_ctrl_pkg.sv | 19 +
 rtl/phase_timer.sv | 30 +++
 rtl/classify_sequencer.sv | 156 +++++++++++++++
 tb/tb_classify_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocr_ctrl_pkg.sv
// Shared types and constants for the OCR classification controller.
// Imported by the sequencer FSM and its testbench.
package ocr_ctrl_pkg;

  localparam int          CLASS_W             = 4;
  localparam int          ADDR_W              = 16;
  localparam int          DEFAULT_NUM_CLASSES = 10;
  localparam logic [3:0]  INVALID_CLASS       = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L_START = 3'd1,
    L_WAIT  = 3'd2,
    A_START = 3'd3,
    A_WAIT  = 3'd4,
    RESULT  = 3'd5
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog counter: cleared at the start of a phase, counts while
// waiting, flags expiry once LIMIT cycles have been spent waiting.
module phase_timer #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count never passes LIMIT-1 because the owner leaves the wait state on expiry.
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/classify_sequencer.sv
// Frame classification controller: starts the scoring layer, then argmax,
// and hands the winning class (or a timeout marker) to the consumer.
//
// Handshakes: img_valid/img_ready transfer a frame when both are high on a
// rising edge in IDLE; res_valid/res_ready transfer a result the same way in
// RESULT, and res_valid with its payload stays stable until that edge.
module classify_sequencer
  import ocr_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES    = DEFAULT_NUM_CLASSES,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               img_valid,
  output logic               img_ready,
  output logic               layer_start,
  input  logic               layer_done,
  input  logic               layer_wr_en,
  input  logic [ADDR_W-1:0]  layer_wr_addr,
  output logic               am_start,
  output logic [ADDR_W-1:0]  am_size,
  input  logic [ADDR_W-1:0]  am_addr,
  input  logic               am_done,
  input  logic [CLASS_W-1:0] am_max_index,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CLASS_W-1:0] res_class,
  output logic               res_timeout,
  output logic               busy,
  output logic [15:0]        class_count,
  output state_t             dbg_state
);

  state_t             r_state;
  logic               r_img_ready;
  logic               r_layer_start;
  logic               r_am_start;
  logic               r_res_valid;
  logic [CLASS_W-1:0] r_res_class;
  logic               r_res_timeout;
  logic               r_busy;
  logic [15:0]        r_class_count;

  logic w_timer_clr;
  logic w_timer_en;
  logic w_expired;

  assign w_timer_clr = (r_state == L_START) || (r_state == A_START);
  assign w_timer_en  = (r_state == L_WAIT)  || (r_state == A_WAIT);

  phase_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clr),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  // Outputs are registered alongside the state so each one matches the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_img_ready   <= 1'b1;
      r_layer_start <= 1'b0;
      r_am_start    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_class   <= '0;
      r_res_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_class_count <= '0;
    end else begin
      r_layer_start <= 1'b0;
      r_am_start    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (img_valid) begin
            r_state       <= L_START;
            r_img_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_layer_start <= 1'b1;
          end
        end
        L_START: r_state <= L_WAIT;
        L_WAIT: begin
          // Done is checked first so it wins over a coincident expiry.
          if (layer_done) begin
            r_state    <= A_START;
            r_am_start <= 1'b1;
          end else if (w_expired) begin
            r_state       <= RESULT;
            r_res_valid   <= 1'b1;
            r_res_class   <= INVALID_CLASS;
            r_res_timeout <= 1'b1;
          end
        end
        A_START: r_state <= A_WAIT;
        A_WAIT: begin
          if (am_done) begin
            r_state       <= RESULT;
            r_res_valid   <= 1'b1;
            r_res_class   <= am_max_index;
            r_res_timeout <= 1'b0;
          end else if (w_expired) begin
            r_state       <= RESULT;
            r_res_valid   <= 1'b1;
            r_res_class   <= INVALID_CLASS;
            r_res_timeout <= 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            r_state       <= IDLE;
            r_res_valid   <= 1'b0;
            r_img_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_class_count <= r_class_count + 16'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_img_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Argmax owns the score RAM read port while it runs; the layer owns it otherwise.
  always_comb begin
    ram_addr = layer_wr_addr;
    ram_we   = 1'b0;
    case (r_state)
      A_START, A_WAIT: ram_addr = am_addr;
      L_WAIT:          ram_we   = layer_wr_en;
      default:         ;
    endcase
  end

  assign img_ready   = r_img_ready;
  assign layer_start = r_layer_start;
  assign am_start    = r_am_start;
  assign am_size     = ADDR_W'(NUM_CLASSES);
  assign res_valid   = r_res_valid;
  assign res_class   = r_res_class;
  assign res_timeout = r_res_timeout;
  assign busy        = r_busy;
  assign class_count = r_class_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_classify_sequencer.sv
// Directed bench for classify_sequencer: a long-timeout instance for the main
// flow and a TIMEOUT_CYCLES=16 instance for the abort paths.
module tb_classify_sequencer;
  import ocr_ctrl_pkg::*;

  logic clk;
  logic reset;

  // Main instance signals
  logic        img_valid, img_ready, layer_start, layer_done, layer_wr_en;
  logic [15:0] layer_wr_addr, am_size, am_addr, ram_addr, class_count;
  logic        am_start, am_done, ram_we, res_valid, res_ready, res_timeout, busy;
  logic [3:0]  am_max_index, res_class;
  state_t      dbg_state;

  // Short-timeout instance signals
  logic        img_valid16, img_ready16, layer_start16, layer_done16, layer_wr_en16;
  logic [15:0] layer_wr_addr16, am_size16, am_addr16, ram_addr16, class_count16;
  logic        am_start16, am_done16, ram_we16, res_valid16, res_ready16, res_timeout16, busy16;
  logic [3:0]  am_max_index16, res_class16;
  state_t      dbg_state16;

  logic [4:0] exp_q[$];
  logic [4:0] exp16_q[$];
  int n_checks;
  int n_pass;
  int n;

  classify_sequencer #(.NUM_CLASSES(10), .TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .reset(reset),
    .img_valid(img_valid), .img_ready(img_ready),
    .layer_start(layer_start), .layer_done(layer_done),
    .layer_wr_en(layer_wr_en), .layer_wr_addr(layer_wr_addr),
    .am_start(am_start), .am_size(am_size), .am_addr(am_addr),
    .am_done(am_done), .am_max_index(am_max_index),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_timeout(res_timeout),
    .busy(busy), .class_count(class_count), .dbg_state(dbg_state)
  );

  classify_sequencer #(.NUM_CLASSES(10), .TIMEOUT_CYCLES(16)) u_dut16 (
    .clk(clk), .reset(reset),
    .img_valid(img_valid16), .img_ready(img_ready16),
    .layer_start(layer_start16), .layer_done(layer_done16),
    .layer_wr_en(layer_wr_en16), .layer_wr_addr(layer_wr_addr16),
    .am_start(am_start16), .am_size(am_size16), .am_addr(am_addr16),
    .am_done(am_done16), .am_max_index(am_max_index16),
    .ram_addr(ram_addr16), .ram_we(ram_we16),
    .res_valid(res_valid16), .res_ready(res_ready16),
    .res_class(res_class16), .res_timeout(res_timeout16),
    .busy(busy16), .class_count(class_count16), .dbg_state(dbg_state16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {26'd0, img_ready, layer_start, am_start, res_valid, res_timeout, busy},
        32'b100000);
    chk({tag, "_class"}, {28'd0, res_class}, 32'd0);
    chk({tag, "_count"}, {16'd0, class_count}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
  endtask

  // Scoreboard monitor: compares every handed-off result against the queue
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_main_unexpected: got %h expected none", {res_timeout, res_class});
      end else begin
        chk("sb_main_result", {27'd0, res_timeout, res_class}, {27'd0, exp_q.pop_front()});
      end
    end
    if (!reset && res_valid16 && res_ready16) begin
      if (exp16_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_t16_unexpected: got %h expected none", {res_timeout16, res_class16});
      end else begin
        chk("sb_t16_result", {27'd0, res_timeout16, res_class16}, {27'd0, exp16_q.pop_front()});
      end
    end
  end

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1;
    img_valid = 0; layer_done = 0; layer_wr_en = 0; layer_wr_addr = '0;
    am_addr = '0; am_done = 0; am_max_index = '0; res_ready = 0;
    img_valid16 = 0; layer_done16 = 0; layer_wr_en16 = 0; layer_wr_addr16 = '0;
    am_addr16 = '0; am_done16 = 0; am_max_index16 = 4'd5; res_ready16 = 0;

    repeat (3) step();
    chk_reset_vals("reset");
    chk("am_size", {16'd0, am_size}, 32'd10);
    reset = 1'b0;
    step();

    // Normal frame: layer done after 20 cycles, argmax 7 after 12, ready on entry
    img_valid = 1;
    exp_q.push_back({1'b0, 4'd7});
    step();
    chk("t1_layer_start", layer_start, 1);
    chk("t1_img_ready", img_ready, 0);
    chk("t1_busy", busy, 1);
    img_valid = 0;
    layer_wr_en = 1; layer_wr_addr = 16'd5;
    #1;
    chk("t1_lstart_we", ram_we, 0);
    chk("t1_lstart_addr", ram_addr, 32'd5);
    step();
    chk("t1_start_pulse", layer_start, 0);
    for (int i = 0; i < 10; i++) begin
      layer_wr_addr = 16'(i);
      #1;
      chk("t1_wr_addr", ram_addr, 32'(i));
      chk("t1_wr_we", ram_we, 1);
      step();
    end
    layer_wr_en = 0;
    #1;
    chk("t1_wr_idle_we", ram_we, 0);
    repeat (8) step();
    layer_done = 1;
    step();
    chk("t1_am_start", am_start, 1);
    chk("t1_state_astart", {29'd0, dbg_state}, {29'd0, A_START});
    layer_done = 0;
    am_addr = 16'd3; layer_wr_en = 1; layer_wr_addr = 16'd9;
    #1;
    chk("t1_astart_addr", ram_addr, 32'd3);
    chk("t1_astart_we", ram_we, 0);
    step();
    chk("t1_am_pulse", am_start, 0);
    for (int i = 0; i < 10; i++) begin
      am_addr = 16'(i);
      #1;
      chk("t1_rd_addr", ram_addr, 32'(i));
      chk("t1_rd_we", ram_we, 0);
      step();
    end
    layer_wr_en = 0;
    step();
    am_done = 1; am_max_index = 4'd7; res_ready = 1;
    step();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_class", {28'd0, res_class}, 32'd7);
    chk("t1_res_timeout", res_timeout, 0);
    step();
    chk("t1_count", {16'd0, class_count}, 32'd1);
    chk("t1_idle_ready", img_ready, 1);
    chk("t1_idle_valid", res_valid, 0);
    res_ready = 0;

    // Stale am_done during A_START, then a held-off result
    img_valid = 1;
    exp_q.push_back({1'b0, 4'd2});
    step();
    img_valid = 0;
    step();
    repeat (2) step();
    layer_done = 1;
    step();
    chk("t2_am_start", am_start, 1);
    layer_done = 0;
    step();
    chk("t2_state_await", {29'd0, dbg_state}, {29'd0, A_WAIT});
    chk("t2_no_stale", res_valid, 0);
    chk("t2_am_pulse", am_start, 0);
    am_done = 0;
    repeat (3) step();
    chk("t2_still_wait", res_valid, 0);
    am_done = 1; am_max_index = 4'd2;
    step();
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res_class", {28'd0, res_class}, 32'd2);
    am_max_index = 4'd9;
    for (int i = 0; i < 50; i++) begin
      img_valid = i[0];
      step();
      chk("t2_hold", {26'd0, res_valid, res_class, res_timeout},
          {26'd0, 1'b1, 4'd2, 1'b0});
      chk("t2_hold_ctl", {29'd0, img_ready, layer_start, busy}, 32'b001);
      chk("t2_hold_count", {16'd0, class_count}, 32'd1);
    end
    img_valid = 0;
    res_ready = 1;
    step();
    chk("t2_count", {16'd0, class_count}, 32'd2);
    chk("t2_state_idle", {29'd0, dbg_state}, {29'd0, IDLE});
    res_ready = 0; am_done = 0;

    // Reset during A_WAIT abandons the frame
    img_valid = 1;
    step();
    img_valid = 0;
    step();
    layer_done = 1;
    step();
    layer_done = 0;
    step();
    step();
    chk("t3_state_await", {29'd0, dbg_state}, {29'd0, A_WAIT});
    reset = 1;
    #1;
    chk_reset_vals("t3_async");
    step();
    chk_reset_vals("t3_next");
    reset = 0;
    am_done = 1; am_max_index = 4'd4; res_ready = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_no_result", {30'd0, res_valid, busy}, 32'd0);
    end
    am_done = 0; res_ready = 0;

    // Short-timeout instance: layer never finishes
    res_ready16 = 1;
    img_valid16 = 1;
    exp16_q.push_back({1'b1, 4'hF});
    step();
    chk("t4_layer_start", layer_start16, 1);
    img_valid16 = 0;
    step();
    n = 0;
    while (dbg_state16 == L_WAIT && n < 100) begin
      n++;
      step();
    end
    chk("t4_lwait_cycles", n, 32'd16);
    chk("t4_res_valid", res_valid16, 1);
    chk("t4_res", {27'd0, res_timeout16, res_class16}, {27'd0, 1'b1, 4'hF});
    step();
    chk("t4_count", {16'd0, class_count16}, 32'd1);

    // Layer done on the expiry cycle wins; argmax then times out
    img_valid16 = 1;
    exp16_q.push_back({1'b1, 4'hF});
    step();
    img_valid16 = 0;
    step();
    repeat (15) step();
    layer_done16 = 1;
    step();
    chk("t5_done_wins", am_start16, 1);
    chk("t5_state_astart", {29'd0, dbg_state16}, {29'd0, A_START});
    layer_done16 = 0;
    step();
    n = 0;
    while (dbg_state16 == A_WAIT && n < 100) begin
      n++;
      step();
    end
    chk("t5_await_cycles", n, 32'd16);
    chk("t5_res", {26'd0, res_valid16, res_timeout16, res_class16}, {26'd0, 1'b1, 1'b1, 4'hF});
    step();
    chk("t5_count", {16'd0, class_count16}, 32'd2);

    repeat (2) step();
    chk("sb_main_drained", exp_q.size(), 32'd0);
    chk("sb_t16_drained", exp16_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
